// File: rtl/tcdm_bank_resp.sv
// Single-port TCDM bank with self-zeroing after reset and a fixed-latency response pipeline.
// Optional load/store statistics counters are enabled by defining TCDM_BANK_STATS_EN.
module tcdm_bank_resp #(
  parameter  int NumWords  = 256,
  parameter  int DataWidth = 32,
  parameter  int RespLat   = 1,
  localparam int AddrWidth = $clog2(NumWords),
  localparam int BeWidth   = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] add_i,
  input  logic                 wen_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 vld_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 busy_o
`ifdef TCDM_BANK_STATS_EN
  ,
  output logic [31:0]          rd_cnt_o,
  output logic [31:0]          wr_cnt_o
`endif
);

  typedef enum logic {
    StInit,
    StReady
  } state_e;

  state_e                 stateReg;
  state_e                 stateNext;
  logic [AddrWidth-1:0]   initCntReg;
  logic                   initWe;
  logic                   initLast;
  logic                   inRange;
  logic                   storeWe;
  logic                   loadRe;
  logic [RespLat-1:0]     vldPipeReg;
  logic [RespLat-1:0]     retPipeReg;
  logic [DataWidth-1:0]   memRdata;
  logic [DataWidth-1:0]   respData;

  // Addresses beyond the last word only exist when NumWords is not a power of two.
  assign inRange  = ({1'b0, add_i} < (AddrWidth + 1)'(NumWords));
  assign initLast = (initCntReg == AddrWidth'(NumWords - 1));
  assign storeWe  = gnt_o & wen_i & inRange;
  assign loadRe   = gnt_o & ~wen_i & inRange;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateReg   <= StInit;
      initCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == StInit) begin
        initCntReg <= initCntReg + AddrWidth'(1);
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    gnt_o     = 1'b0;
    busy_o    = 1'b1;
    initWe    = 1'b0;
    case (stateReg)
      StInit: begin
        initWe = 1'b1;
        if (initLast) begin
          stateNext = StReady;
        end
      end
      StReady: begin
        busy_o = 1'b0;
        gnt_o  = req_i;
      end
      default: begin
        stateNext = StInit;
      end
    endcase
  end

  // One byte-wide array per lane so each lane maps onto a plain RAM with its own write enable.
  for (genvar gi = 0; gi < BeWidth; gi++) begin : gen_lane
    logic [7:0] laneMem [NumWords];
    logic [7:0] laneRdReg;

    always_ff @(posedge clk_i) begin
      if (initWe) begin
        laneMem[initCntReg] <= 8'h00;
      end else if (storeWe && be_i[gi]) begin
        laneMem[add_i] <= wdata_i[gi*8 +: 8];
      end
      if (loadRe) begin
        laneRdReg <= laneMem[add_i];
      end
    end

    assign memRdata[gi*8 +: 8] = laneRdReg;
  end

  // The RAM output register is the first pipeline stage; later stages only delay it.
  if (RespLat == 1) begin : gen_lat_one
    assign respData = memRdata;
  end else begin : gen_lat_multi
    logic [DataWidth-1:0] dataPipeReg [RespLat-1];

    always_ff @(posedge clk_i) begin
      dataPipeReg[0] <= memRdata;
      for (int i = 1; i < RespLat - 1; i++) begin
        dataPipeReg[i] <= dataPipeReg[i-1];
      end
    end

    assign respData = dataPipeReg[RespLat-2];
  end

  // retPipeReg marks responses that carry real load data; the data stages are never reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vldPipeReg <= '0;
      retPipeReg <= '0;
    end else begin
      vldPipeReg[0] <= gnt_o;
      retPipeReg[0] <= loadRe;
      for (int i = 1; i < RespLat; i++) begin
        vldPipeReg[i] <= vldPipeReg[i-1];
        retPipeReg[i] <= retPipeReg[i-1];
      end
    end
  end

  assign vld_o   = vldPipeReg[RespLat-1];
  assign rdata_o = (vldPipeReg[RespLat-1] && retPipeReg[RespLat-1]) ? respData : '0;

`ifdef TCDM_BANK_STATS_EN
  logic [31:0] rdCntReg;
  logic [31:0] wrCntReg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdCntReg <= '0;
      wrCntReg <= '0;
    end else begin
      if (gnt_o && !wen_i && (rdCntReg != 32'hFFFF_FFFF)) begin
        rdCntReg <= rdCntReg + 32'd1;
      end
      if (gnt_o && wen_i && (wrCntReg != 32'hFFFF_FFFF)) begin
        wrCntReg <= wrCntReg + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rdCntReg;
  assign wr_cnt_o = wrCntReg;
`endif

endmodule

// File: tb/tb_tcdm_bank_resp.sv
// Directed bench for tcdm_bank_resp with NumWords=16, DataWidth=32, RespLat=2.
// Stats checks are compiled in only when TCDM_BANK_STATS_EN is defined.
module tb_tcdm_bank_resp;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        req_i   = 1'b0;
  logic        wen_i   = 1'b0;
  logic [3:0]  add_i   = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i    = '0;
  logic        gnt_o;
  logic        vld_o;
  logic [31:0] rdata_o;
  logic        busy_o;
`ifdef TCDM_BANK_STATS_EN
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  tcdm_bank_resp #(
    .NumWords (16),
    .DataWidth(32),
    .RespLat  (2)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .add_i   (add_i),
    .wen_i   (wen_i),
    .wdata_i (wdata_i),
    .be_i    (be_i),
    .vld_o   (vld_o),
    .rdata_o (rdata_o),
    .busy_o  (busy_o)
`ifdef TCDM_BANK_STATS_EN
    ,
    .rd_cnt_o(rd_cnt_o),
    .wr_cnt_o(wr_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive one READY-state cycle, check outputs, advance to next posedge+1.
  task automatic cyc(input string tag, input logic req, input logic wen, input logic [3:0] add,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic expVld, input logic [31:0] expRdata);
    req_i   = req;
    wen_i   = wen;
    add_i   = add;
    wdata_i = wd;
    be_i    = be;
    #1;
    checkEq({tag, ".gnt"}, {31'd0, gnt_o}, {31'd0, req});
    checkEq({tag, ".vld"}, {31'd0, vld_o}, {31'd0, expVld});
    checkEq({tag, ".rdata"}, rdata_o, expRdata);
    $display("%-10s req=%0b wen=%0b add=%0d wdata=%h be=%b | gnt=%0b vld=%0b rdata=%h",
             tag, req, wen, add, wd, be, gnt_o, vld_o, rdata_o);
    @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1 right after reset release, with req_i held high.
  task automatic initSeq(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      checkEq({tag, ".busy"}, {31'd0, busy_o}, 32'd1);
      checkEq({tag, ".gnt"}, {31'd0, gnt_o}, 32'd0);
      checkEq({tag, ".vld"}, {31'd0, vld_o}, 32'd0);
      @(posedge clk_i);
      #1;
    end
    checkEq({tag, ".busy_done"}, {31'd0, busy_o}, 32'd0);
    $display("%-10s init sequence complete", tag);
  endtask

  initial begin
    req_i = 1'b1;
    #1;
    checkEq("rst.gnt", {31'd0, gnt_o}, 32'd0);
    checkEq("rst.busy", {31'd0, busy_o}, 32'd1);
    checkEq("rst.vld", {31'd0, vld_o}, 32'd0);
    checkEq("rst.rdata", rdata_o, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    initSeq("init");

    cyc("ld5",      1, 0, 5, 32'h0, 4'h0, 0, 32'h0);
    cyc("idle",     0, 0, 0, 32'h0, 4'h0, 0, 32'h0);
    cyc("ld5.rsp",  0, 0, 0, 32'h0, 4'h0, 1, 32'h0);

    cyc("st3",      1, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 32'h0);
    cyc("ld3",      1, 0, 3, 32'h0, 4'h0, 0, 32'h0);
    cyc("st3.rsp",  0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
    cyc("ld3.rsp",  0, 0, 0, 32'h0, 4'h0, 1, 32'h00BB00DD);
    cyc("st3b",     1, 1, 3, 32'h11223344, 4'b1010, 0, 32'h0);
    cyc("ld3b",     1, 0, 3, 32'h0, 4'h0, 0, 32'h0);
    cyc("st3b.rsp", 0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
    cyc("ld3b.rsp", 0, 0, 0, 32'h0, 4'h0, 1, 32'h11BB33DD);

    for (int i = 0; i < 8; i++) begin
      cyc("pre", 1, 1, 4'(i), 32'(i), 4'hF, (i >= 2), 32'h0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc("stream", 1, 0, 4'(j), 32'h0, 4'h0, 1, (j >= 2) ? 32'(j - 2) : 32'h0);
    end
    cyc("tail6",    0, 0, 0, 32'h0, 4'h0, 1, 32'd6);
    cyc("tail7",    0, 0, 0, 32'h0, 4'h0, 1, 32'd7);
    cyc("tailend",  0, 0, 0, 32'h0, 4'h0, 0, 32'h0);

    cyc("st9",      1, 1, 9, 32'h12345678, 4'hF, 0, 32'h0);
    cyc("ld9",      1, 0, 9, 32'h0, 4'h0, 0, 32'h0);
    cyc("st9.rsp",  0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
    cyc("ld9.rsp",  0, 0, 0, 32'h0, 4'h0, 1, 32'h12345678);
    cyc("idle",     0, 0, 0, 32'h0, 4'h0, 0, 32'h0);

    // Reset one cycle after a granted load: its response must never appear.
    cyc("ld9r",     1, 0, 9, 32'h0, 4'h0, 0, 32'h0);
    rst_ni = 1'b0;
    req_i  = 1'b1;
    wen_i  = 1'b0;
    #1;
    checkEq("mrst.busy", {31'd0, busy_o}, 32'd1);
    checkEq("mrst.gnt", {31'd0, gnt_o}, 32'd0);
    checkEq("mrst.vld", {31'd0, vld_o}, 32'd0);
    checkEq("mrst.rdata", rdata_o, 32'd0);
    @(posedge clk_i);
    #1;
    checkEq("mrst.vld2", {31'd0, vld_o}, 32'd0);
    rst_ni = 1'b1;
    initSeq("reinit");

    cyc("post.ld9", 1, 0, 9, 32'h0, 4'h0, 0, 32'h0);
    cyc("idle",     0, 0, 0, 32'h0, 4'h0, 0, 32'h0);
    cyc("post.rsp", 0, 0, 0, 32'h0, 4'h0, 1, 32'h0);

    cyc("s.ld1",    1, 0, 1, 32'h0, 4'h0, 0, 32'h0);
    cyc("s.ld2",    1, 0, 2, 32'h0, 4'h0, 0, 32'h0);
    cyc("s.st3",    1, 1, 3, 32'hCAFEF00D, 4'hF, 1, 32'h0);
    cyc("s.st4",    1, 1, 4, 32'hDEADBEEF, 4'hF, 1, 32'h0);
`ifdef TCDM_BANK_STATS_EN
    checkEq("stats.rd", rd_cnt_o, 32'd3);
    checkEq("stats.wr", wr_cnt_o, 32'd2);
    force dut.rdCntReg = 32'hFFFF_FFFF;
    #1;
    release dut.rdCntReg;
`endif
    cyc("s.sat",    1, 0, 0, 32'h0, 4'h0, 1, 32'h0);
`ifdef TCDM_BANK_STATS_EN
    checkEq("stats.rd_sat", rd_cnt_o, 32'hFFFF_FFFF);
    checkEq("stats.wr_hold", wr_cnt_o, 32'd2);
`endif
    cyc("s.rsp",    0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
    cyc("s.last",   0, 0, 0, 32'h0, 4'h0, 1, 32'h0);
    cyc("s.end",    0, 0, 0, 32'h0, 4'h0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
